// File: rtl/route_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// route_sequencer_pkg
//   Shared definitions for the route sequencer and the line-following
//   direction block.
//   - Steering codes: [3:2] side (10 right, 01 left, 00 none, 11 stop),
//     [1:0] strength.
//   - Route action encodings.
//   - Motor command encodings, laid out as {l_en, l_rev, r_en, r_rev}.
//   - FSM state type and the counter width.
//   - follow_cmd(): line-following motor command for a steering code.
// -----------------------------------------------------------------------------
package route_sequencer_pkg;

    // 26 bits reaches the longest dwell the sequencer has to time.
    localparam int CNT_W = 26;

    // Steering codes produced by the direction block
    localparam logic [3:0] DIR_PROCEED  = 4'b0000;
    localparam logic [3:0] DIR_STOP     = 4'b1111;
    localparam logic [3:0] DIR_VEER_R   = 4'b1001;
    localparam logic [3:0] DIR_HARD_R   = 4'b1010;
    localparam logic [3:0] DIR_NINETY_R = 4'b1011;
    localparam logic [3:0] DIR_VEER_L   = 4'b0101;
    localparam logic [3:0] DIR_HARD_L   = 4'b0110;
    localparam logic [3:0] DIR_NINETY_L = 4'b0111;

    // Side field, dir_code[3:2]
    localparam logic [1:0] SIDE_NONE  = 2'b00;
    localparam logic [1:0] SIDE_LEFT  = 2'b01;
    localparam logic [1:0] SIDE_RIGHT = 2'b10;
    localparam logic [1:0] SIDE_STOP  = 2'b11;

    // Intersection actions stored in the route table
    typedef enum logic [1:0] {
        ACT_STRAIGHT = 2'b00,
        ACT_LEFT     = 2'b01,
        ACT_RIGHT    = 2'b10,
        ACT_REVERSE  = 2'b11
    } action_e;

    // Motor commands {l_en, l_rev, r_en, r_rev}
    localparam logic [3:0] MOTOR_OFF     = 4'b0000;
    localparam logic [3:0] MOTOR_FWD     = 4'b1010;
    localparam logic [3:0] MOTOR_STEER_R = 4'b1000;  // left wheel only
    localparam logic [3:0] MOTOR_STEER_L = 4'b0010;  // right wheel only
    localparam logic [3:0] MOTOR_PIVOT_L = 4'b0110;
    localparam logic [3:0] MOTOR_PIVOT_R = 4'b1001;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FOLLOW  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_TURN    = 3'd3,
        ST_RELEASE = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_e;

    // Line-following motor command. Named codes are listed explicitly; any
    // other code falls back to its side field, so every 11_xx code is a stop.
    function automatic logic [3:0] follow_cmd(input logic [3:0] code);
        logic [3:0] cmd;
        cmd = MOTOR_OFF;
        case (code)
            DIR_PROCEED:                           cmd = MOTOR_FWD;
            DIR_VEER_R, DIR_HARD_R, DIR_NINETY_R:  cmd = MOTOR_STEER_R;
            DIR_VEER_L, DIR_HARD_L, DIR_NINETY_L:  cmd = MOTOR_STEER_L;
            default: begin
                case (code[3:2])
                    SIDE_NONE:  cmd = MOTOR_FWD;
                    SIDE_RIGHT: cmd = MOTOR_STEER_R;
                    SIDE_LEFT:  cmd = MOTOR_STEER_L;
                    default:    cmd = MOTOR_OFF;
                endcase
            end
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/sequencer_timer.sv
// -----------------------------------------------------------------------------
// sequencer_timer
//   Loadable down-counter with a terminal-count flag. The counter stops at
//   zero (saturates) and is reloaded whenever the sequencer enters a timed
//   state.
//   Ports:
//     clk        system clock
//     rst        asynchronous active-high reset (clears the count)
//     load_i     load load_val_i this cycle instead of counting
//     load_val_i value to load (cycles to wait minus one)
//     tc_o       high while the count is zero
// -----------------------------------------------------------------------------
module sequencer_timer
    import route_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/route_sequencer.sv
// -----------------------------------------------------------------------------
// route_sequencer
//   Mission-level controller above the line-following direction block. Follows
//   the line from the steering code, and at every intersection (stop code)
//   dwells, then executes the next action of a fixed route table.
//   Ports:
//     clk          system clock
//     rst          asynchronous active-high reset
//     start        one-cycle pulse, begins the route from entry 0
//     dir_code     steering code from the direction block
//     direction    1 = forwards, 0 = backwards (fed back to direction block)
//     motor_cmd    {l_en, l_rev, r_en, r_rev}
//     node_idx     index of the next route entry to execute
//     busy         high in every state except IDLE and DONE
//     done         high in DONE
//     dbg_state_o  current FSM state, for observation only
// -----------------------------------------------------------------------------
module route_sequencer
    import route_sequencer_pkg::*;
#(
    parameter int                      ROUTE_LEN     = 4,
    parameter logic [2*ROUTE_LEN-1:0]  ROUTE         = 8'b11_10_00_01,
    parameter int                      SETTLE_CYCLES = 25_000_000,
    parameter int                      TURN_CYCLES   = 40_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  dir_code,
    output logic        direction,
    output logic [3:0]  motor_cmd,
    output logic [3:0]  node_idx,
    output logic        busy,
    output logic        done,
    output seq_state_e  dbg_state_o
);

    // The timer is loaded on the entry edge and the action fires on the edge
    // where it reads zero, so loading N-1 gives exactly N cycles in the state.
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);

    // Route widened to 32 bits so indexing with node_idx == ROUTE_LEN stays
    // in range; that entry is never acted on.
    localparam logic [31:0] ROUTE_EXT = 32'(ROUTE);

    seq_state_e  state_q;
    logic [3:0]  motor_cmd_q;
    logic        direction_q;
    logic [3:0]  node_idx_q;
    logic        busy_q;
    logic        done_q;

    logic        timer_load;
    logic [CNT_W-1:0] timer_load_val;
    logic        timer_tc;

    action_e     cur_action;
    logic        stop_seen;
    logic        route_end;
    logic        turn_next;

    assign cur_action = action_e'(ROUTE_EXT[{node_idx_q, 1'b0} +: 2]);
    assign stop_seen  = (dir_code[3:2] == SIDE_STOP);
    assign route_end  = (node_idx_q == 4'(ROUTE_LEN));
    assign turn_next  = (cur_action == ACT_LEFT) || (cur_action == ACT_RIGHT);

    // Reload the timer on the edges that enter SETTLE or TURN.
    always_comb begin
        timer_load     = 1'b0;
        timer_load_val = SETTLE_LOAD;
        if (state_q == ST_FOLLOW && stop_seen) begin
            timer_load = 1'b1;
        end else if (state_q == ST_SETTLE && timer_tc && !route_end && turn_next) begin
            timer_load     = 1'b1;
            timer_load_val = TURN_LOAD;
        end
    end

    sequencer_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_load_val),
        .tc_o       (timer_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            motor_cmd_q <= MOTOR_OFF;
            direction_q <= 1'b1;
            node_idx_q  <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    motor_cmd_q <= MOTOR_OFF;
                    if (start) begin
                        // A stop code arriving with start is acted on from
                        // FOLLOW on the next edge.
                        state_q     <= ST_FOLLOW;
                        motor_cmd_q <= follow_cmd(dir_code);
                        node_idx_q  <= 4'd0;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                    end
                end

                ST_FOLLOW: begin
                    motor_cmd_q <= follow_cmd(dir_code);
                    if (stop_seen) begin
                        state_q <= ST_SETTLE;
                    end
                end

                ST_SETTLE: begin
                    motor_cmd_q <= MOTOR_OFF;
                    if (timer_tc) begin
                        if (route_end) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            node_idx_q <= node_idx_q + 4'd1;
                            case (cur_action)
                                ACT_STRAIGHT: begin
                                    state_q     <= ST_RELEASE;
                                    motor_cmd_q <= MOTOR_FWD;
                                end
                                ACT_LEFT: begin
                                    state_q     <= ST_TURN;
                                    motor_cmd_q <= MOTOR_PIVOT_L;
                                end
                                ACT_RIGHT: begin
                                    state_q     <= ST_TURN;
                                    motor_cmd_q <= MOTOR_PIVOT_R;
                                end
                                default: begin
                                    direction_q <= ~direction_q;
                                    state_q     <= ST_RELEASE;
                                    motor_cmd_q <= MOTOR_FWD;
                                end
                            endcase
                        end
                    end
                end

                ST_TURN: begin
                    // Line re-acquisition wins over a coincident timeout.
                    if (dir_code[3:2] == SIDE_NONE) begin
                        state_q     <= ST_FOLLOW;
                        motor_cmd_q <= follow_cmd(dir_code);
                    end else if (timer_tc) begin
                        state_q     <= ST_DONE;
                        motor_cmd_q <= MOTOR_OFF;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end

                ST_RELEASE: begin
                    // Drive off the node before line following can see a
                    // stop again.
                    motor_cmd_q <= MOTOR_FWD;
                    if (dir_code != DIR_STOP) begin
                        state_q     <= ST_FOLLOW;
                        motor_cmd_q <= follow_cmd(dir_code);
                    end
                end

                default: begin
                    state_q     <= ST_IDLE;
                    motor_cmd_q <= MOTOR_OFF;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign direction   = direction_q;
    assign motor_cmd   = motor_cmd_q;
    assign node_idx    = node_idx_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_route_sequencer.sv
module tb_route_sequencer;
  import route_sequencer_pkg::*;

  localparam int SETTLE_N = 4;
  localparam int TURN_N   = 20;
  localparam int LEN      = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] dir_code = 4'b0000;

  logic       direction;
  logic [3:0] motor_cmd;
  logic [3:0] node_idx;
  logic       busy;
  logic       done;
  seq_state_e dbg_state;

  always #5 clk = ~clk;

  route_sequencer #(
    .ROUTE_LEN     (4),
    .ROUTE         (8'b11_10_00_01),
    .SETTLE_CYCLES (SETTLE_N),
    .TURN_CYCLES   (TURN_N)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dir_code    (dir_code),
    .direction   (direction),
    .motor_cmd   (motor_cmd),
    .node_idx    (node_idx),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  // Mission phase plus elapsed cycles in the current dwell; route actions as
  // plain integers: 0 straight, 1 left, 2 right, 3 reverse.
  localparam int P_IDLE = 0, P_FOLLOW = 1, P_SETTLE = 2, P_TURN = 3, P_RELEASE = 4, P_DONE = 5;
  int route_tbl[LEN] = '{1, 0, 2, 3};

  int         m_phase = P_IDLE;
  int         m_elapsed = 0;
  int         m_next = 0;
  logic       m_dir = 1'b1;
  logic [3:0] m_motor = 4'b0000;
  logic       m_done = 1'b0;

  function automatic logic [3:0] follow_motor(input logic [3:0] c);
    if (c[3:2] == 2'b00) return 4'b1010;
    if (c[3:2] == 2'b10) return 4'b1000;
    if (c[3:2] == 2'b01) return 4'b0010;
    return 4'b0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = P_IDLE; m_elapsed = 0; m_next = 0;
      m_dir = 1'b1; m_motor = 4'b0000; m_done = 1'b0;
    end else begin
      case (m_phase)
        P_IDLE, P_DONE: begin
          if (start) begin
            m_phase = P_FOLLOW; m_next = 0; m_done = 1'b0;
            m_motor = follow_motor(dir_code);
          end
        end
        P_FOLLOW: begin
          m_motor = follow_motor(dir_code);
          if (dir_code[3:2] == 2'b11) begin
            m_phase = P_SETTLE; m_elapsed = 0;
          end
        end
        P_SETTLE: begin
          m_motor = 4'b0000;
          m_elapsed++;
          if (m_elapsed == SETTLE_N) begin
            if (m_next == LEN) begin
              m_phase = P_DONE; m_done = 1'b1;
            end else begin
              case (route_tbl[m_next])
                0: begin m_phase = P_RELEASE; m_motor = 4'b1010; end
                1: begin m_phase = P_TURN; m_motor = 4'b0110; m_elapsed = 0; end
                2: begin m_phase = P_TURN; m_motor = 4'b1001; m_elapsed = 0; end
                default: begin m_phase = P_RELEASE; m_motor = 4'b1010; m_dir = ~m_dir; end
              endcase
              m_next++;
            end
          end
        end
        P_TURN: begin
          if (dir_code[3:2] == 2'b00) begin
            m_phase = P_FOLLOW; m_motor = follow_motor(dir_code);
          end else begin
            m_elapsed++;
            if (m_elapsed == TURN_N) begin
              m_phase = P_DONE; m_motor = 4'b0000; m_done = 1'b1;
            end
          end
        end
        default: begin // release
          m_motor = 4'b1010;
          if (dir_code != 4'b1111) begin
            m_phase = P_FOLLOW; m_motor = follow_motor(dir_code);
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model while out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("model_motor", motor_cmd, m_motor);
      check("model_direction", {3'b000, direction}, {3'b000, m_dir});
      check("model_node_idx", node_idx, 4'(m_next));
      check("model_busy", {3'b000, busy},
            {3'b000, (m_phase != P_IDLE && m_phase != P_DONE)});
      check("model_done", {3'b000, done}, {3'b000, m_done});
    end
  end

  // Hand-computed expectations
  task automatic expect_lit(input string name, input logic [3:0] e_motor, input logic e_dir,
                            input logic [3:0] e_node, input logic e_busy, input logic e_done);
    check({name, "_motor"}, motor_cmd, e_motor);
    check({name, "_dir"}, {3'b000, direction}, {3'b000, e_dir});
    check({name, "_node"}, node_idx, e_node);
    check({name, "_busy"}, {3'b000, busy}, {3'b000, e_busy});
    check({name, "_done"}, {3'b000, done}, {3'b000, e_done});
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [3:0] code);
    start = 1'b1;
    dir_code = code;
    tick();
    start = 1'b0;
  endtask

  // Stop code held through the dwell: 1 edge into SETTLE plus SETTLE_N edges.
  task automatic hit_node();
    dir_code = 4'b1111;
    repeat (SETTLE_N + 1) tick();
  endtask

  initial begin
    repeat (3) tick();
    expect_lit("reset", 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    expect_lit("idle", 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0);

    // Line following
    pulse_start(4'b0000);
    expect_lit("follow_fwd", 4'b1010, 1'b1, 4'd0, 1'b1, 1'b0);
    dir_code = 4'b1010; tick();
    expect_lit("follow_right", 4'b1000, 1'b1, 4'd0, 1'b1, 1'b0);
    dir_code = 4'b0110; tick();
    expect_lit("follow_left", 4'b0010, 1'b1, 4'd0, 1'b1, 1'b0);
    pulse_start(4'b0000);
    expect_lit("start_while_busy", 4'b1010, 1'b1, 4'd0, 1'b1, 1'b0);

    // Node 0: LEFT
    dir_code = 4'b1111;
    repeat (SETTLE_N) begin
      tick();
      expect_lit("settle_dwell", 4'b0000, 1'b1, 4'd0, 1'b1, 1'b0);
    end
    tick();
    expect_lit("left_pivot", 4'b0110, 1'b1, 4'd1, 1'b1, 1'b0);
    tick();
    expect_lit("turn_ignores_stop", 4'b0110, 1'b1, 4'd1, 1'b1, 1'b0);
    dir_code = 4'b0000; tick();
    expect_lit("left_reacquire", 4'b1010, 1'b1, 4'd1, 1'b1, 1'b0);

    // Node 1: STRAIGHT
    hit_node();
    expect_lit("straight_release", 4'b1010, 1'b1, 4'd2, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      expect_lit("release_holds_on_stop", 4'b1010, 1'b1, 4'd2, 1'b1, 1'b0);
    end
    dir_code = 4'b0000; tick();
    dir_code = 4'b0110; tick();
    expect_lit("release_to_follow", 4'b0010, 1'b1, 4'd2, 1'b1, 1'b0);

    // Node 2: RIGHT
    hit_node();
    expect_lit("right_pivot", 4'b1001, 1'b1, 4'd3, 1'b1, 1'b0);
    dir_code = 4'b0000; tick();

    // Node 3: REVERSE
    hit_node();
    expect_lit("reverse_toggle", 4'b1010, 1'b0, 4'd4, 1'b1, 1'b0);
    dir_code = 4'b0000; tick();

    // Fifth stop ends the route
    hit_node();
    expect_lit("route_done", 4'b0000, 1'b0, 4'd4, 1'b0, 1'b1);
    tick();
    expect_lit("done_holds", 4'b0000, 1'b0, 4'd4, 1'b0, 1'b1);

    // Pivot timeout
    pulse_start(4'b0000);
    expect_lit("restart", 4'b1010, 1'b0, 4'd0, 1'b1, 1'b0);
    hit_node();
    expect_lit("timeout_pivot", 4'b0110, 1'b0, 4'd1, 1'b1, 1'b0);
    dir_code = 4'b1010;
    repeat (TURN_N - 1) tick();
    expect_lit("timeout_last_pivot", 4'b0110, 1'b0, 4'd1, 1'b1, 1'b0);
    tick();
    expect_lit("timeout_done", 4'b0000, 1'b0, 4'd1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a pivot
    pulse_start(4'b0000);
    hit_node();
    expect_lit("pre_reset_pivot", 4'b0110, 1'b0, 4'd1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    tick();
    expect_lit("reset_mid_turn", 4'b0000, 1'b1, 4'd0, 1'b0, 1'b0);
    check("reset_state_idle", {1'b0, dbg_state}, {1'b0, ST_IDLE});
    rst = 1'b0;
    tick();

    // Start coincident with a stop code
    pulse_start(4'b1111);
    expect_lit("start_on_stop", 4'b0000, 1'b1, 4'd0, 1'b1, 1'b0);
    repeat (SETTLE_N) tick();
    expect_lit("stop_dwell", 4'b0000, 1'b1, 4'd0, 1'b1, 1'b0);
    tick();
    expect_lit("stop_acted_next", 4'b0110, 1'b1, 4'd1, 1'b1, 1'b0);
    dir_code = 4'b0000; tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
